ps2_poly_receiver: RTL and testbench

//   PS/2 keyboard receiver with multi-key tracking. Synchronises ps2_clk/ps2_data,

---
 rtl/ps2_poly_receiver.sv | 213 +++++++++++++++++++++
 tb/tb_ps2_poly_receiver.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_poly_receiver.sv
// ps2_poly_receiver: PS/2 keyboard receiver that deframes scan codes, decodes the
// E0/F0 prefixes and keeps an ordered table of currently held keys (oldest in slot 0).
module ps2_poly_receiver #(
    parameter int NUM_KEYS       = 4,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic                  sys_clk,
    input  logic                  async_rst_n,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    output logic [7:0]            key,
    output logic                  key_ext,
    output logic [9*NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0]   key_valid,
    output logic                  event_valid,
    output logic [8:0]            event_code,
    output logic                  event_break,
    output logic                  frame_err,
    output logic                  overflow
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall;
    logic                   data_bit;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          parity_ok;
    logic [TW-1:0] stall_cnt;
    logic          byte_valid;
    logic [7:0]    byte_data;

    logic                ext_flag;
    logic                brk_flag;
    logic [8:0]          slot [NUM_KEYS];
    logic [NUM_KEYS-1:0] used;

    logic       held_hit;
    int         hit_idx;
    int         fill;
    logic [8:0] code_in;

    // Bring the PS/2 lines into the sys_clk domain; idle-high lines reset to 1 so no false fall
    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall     = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_bit = data_sync[SYNC_STAGES-1];

    // Frame deserialiser advancing on each PS/2 clock fall, with a mid-frame stall watchdog
    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shift      <= 8'h00;
            parity_ok  <= 1'b0;
            stall_cnt  <= '0;
            byte_valid <= 1'b0;
            byte_data  <= 8'h00;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                stall_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_bit) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_bit, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_ok <= data_bit ^ (^shift);
                        state     <= STOP;
                    end
                    default: begin
                        if (data_bit && parity_ok) begin
                            byte_valid <= 1'b1;
                            byte_data  <= shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                endcase
            end else if (state == IDLE) begin
                stall_cnt <= '0;
            end else if (stall_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + TW'(1);
            end
        end
    end

    // Look up the incoming code in the table and find the first free slot (table stays packed)
    always_comb begin
        code_in  = {ext_flag, byte_data};
        held_hit = 1'b0;
        hit_idx  = 0;
        fill     = 0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (used[i]) begin
                fill = i + 1;
                if (slot[i] == code_in) begin
                    held_hit = 1'b1;
                    hit_idx  = i;
                end
            end
        end
    end

    // Prefix tracking and held-key table update, one action per received byte
    always_ff @(posedge sys_clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                slot[i] <= 9'h000;
            end
            used        <= '0;
            ext_flag    <= 1'b0;
            brk_flag    <= 1'b0;
            event_valid <= 1'b0;
            event_code  <= 9'h000;
            event_break <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            event_valid <= 1'b0;
            overflow    <= 1'b0;
            if (frame_err) begin
                ext_flag <= 1'b0;
                brk_flag <= 1'b0;
            end else if (byte_valid) begin
                if (byte_data == 8'hE0) begin
                    ext_flag <= 1'b1;
                end else if (byte_data == 8'hF0) begin
                    brk_flag <= 1'b1;
                end else begin
                    ext_flag <= 1'b0;
                    brk_flag <= 1'b0;
                    if (byte_data != 8'h00 && byte_data != 8'hFF) begin
                        if (brk_flag) begin
                            if (held_hit) begin
                                for (int i = 0; i < NUM_KEYS - 1; i++) begin
                                    if (i >= hit_idx) begin
                                        slot[i] <= slot[i+1];
                                        used[i] <= used[i+1];
                                    end
                                end
                                slot[NUM_KEYS-1] <= 9'h000;
                                used[NUM_KEYS-1] <= 1'b0;
                                event_valid      <= 1'b1;
                                event_code       <= code_in;
                                event_break      <= 1'b1;
                            end
                        end else if (!held_hit) begin
                            if (used[NUM_KEYS-1]) begin
                                overflow <= 1'b1;
                            end else begin
                                slot[fill]  <= code_in;
                                used[fill]  <= 1'b1;
                                event_valid <= 1'b1;
                                event_code  <= code_in;
                                event_break <= 1'b0;
                            end
                        end
                    end
                end
            end
        end
    end

    // Flatten the table for the voice logic
    always_comb begin
        keys = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            keys[9*i +: 9] = slot[i];
        end
    end

    assign key       = slot[0][7:0];
    assign key_ext   = slot[0][8];
    assign key_valid = used;

endmodule

// File: tb/tb_ps2_poly_receiver.sv
// tb_ps2_poly_receiver: drives PS/2 frames into ps2_poly_receiver and checks every cycle
// against a queue-based model of the held-key table, plus hand-computed literal snapshots.
`timescale 1ns/1ps
module tb_ps2_poly_receiver;
    localparam int NK   = 4;
    localparam int SS   = 2;
    localparam int TO   = 200;
    localparam int HALF = 20;
    localparam int LAT  = SS + 2;

    logic          sys_clk     = 1'b0;
    logic          async_rst_n = 1'b1;
    logic          ps2_clk     = 1'b1;
    logic          ps2_data    = 1'b1;
    logic [7:0]    key;
    logic          key_ext;
    logic [9*NK-1:0] keys;
    logic [NK-1:0] key_valid;
    logic          event_valid;
    logic [8:0]    event_code;
    logic          event_break;
    logic          frame_err;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int         post_seq  = 0;
    int         post_cyc  = 0;
    logic [7:0] post_byte = 8'h00;
    bit         post_err  = 1'b0;
    int         post_win  = 0;

    int              lit_seq     = 0;
    logic [7:0]      lit_key     = 8'h00;
    bit              lit_ext     = 1'b0;
    logic [NK-1:0]   lit_kv      = '0;
    int              lit_ev      = 0;
    int              lit_ovf     = 0;
    int              lit_ferr    = 0;
    logic [8:0]      lit_code    = 9'h000;
    bit              lit_keys_en = 1'b0;
    logic [9*NK-1:0] lit_keys    = '0;

    logic [8:0] held [$];
    bit         ext_f = 1'b0;
    bit         brk_f = 1'b0;

    ps2_poly_receiver #(
        .NUM_KEYS      (NK),
        .SYNC_STAGES   (SS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sys_clk    (sys_clk),
        .async_rst_n(async_rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .key        (key),
        .key_ext    (key_ext),
        .keys       (keys),
        .key_valid  (key_valid),
        .event_valid(event_valid),
        .event_code (event_code),
        .event_break(event_break),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    // 100 MHz system clock
    always #5 sys_clk = ~sys_clk;

    // Cycle index used to time expected pulses
    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Keyboard-level meaning of one received byte applied to the held-key list
    task automatic model_byte(input logic [7:0] b, output bit ev, output logic [8:0] code,
                              output bit is_brk, output bit ovf);
        int idx;
        ev     = 1'b0;
        code   = 9'h000;
        is_brk = 1'b0;
        ovf    = 1'b0;
        if (b == 8'hE0) begin
            ext_f = 1'b1;
        end else if (b == 8'hF0) begin
            brk_f = 1'b1;
        end else if (b == 8'h00 || b == 8'hFF) begin
            ext_f = 1'b0;
            brk_f = 1'b0;
        end else begin
            code = {ext_f, b};
            idx  = -1;
            foreach (held[i]) if (held[i] == code) idx = i;
            if (brk_f) begin
                if (idx >= 0) begin
                    held.delete(idx);
                    ev     = 1'b1;
                    is_brk = 1'b1;
                end
            end else if (idx < 0) begin
                if (held.size() < NK) begin
                    held.push_back(code);
                    ev = 1'b1;
                end else begin
                    ovf = 1'b1;
                end
            end
            ext_f = 1'b0;
            brk_f = 1'b0;
        end
    endtask

    function automatic logic [8:0] model_slot0();
        return (held.size() > 0) ? held[0] : 9'h000;
    endfunction

    function automatic logic [9*NK-1:0] model_keys();
        logic [9*NK-1:0] r;
        r = '0;
        foreach (held[i]) r[9*i +: 9] = held[i];
        return r;
    endfunction

    function automatic logic [NK-1:0] model_kv();
        logic [NK-1:0] r;
        r = '0;
        for (int i = 0; i < held.size(); i++) r[i] = 1'b1;
        return r;
    endfunction

    // Send one PS/2 frame (or its first nbits bits) with odd parity computed here
    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                                 input int nbits, input bit expect_to);
        logic [10:0] bits;
        bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge sys_clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge sys_clk);
            ps2_clk = 1'b0;
            if (i == 10 || (expect_to && i == nbits - 1)) begin
                post_cyc  = cyc;
                post_byte = b;
                post_err  = bad_par | bad_stop | expect_to;
                post_win  = expect_to ? TO + 20 : 10;
                post_seq++;
            end
            repeat (HALF) @(negedge sys_clk);
            ps2_clk = 1'b1;
        end
        @(negedge sys_clk);
        ps2_data = 1'b1;
        repeat (60) @(negedge sys_clk);
    endtask

    task automatic post_literal(input logic [7:0] k, input bit e, input logic [NK-1:0] kv,
                                input int ev, input int ovf, input int ferr, input logic [8:0] lc,
                                input bit keys_en, input logic [9*NK-1:0] kk);
        lit_key     = k;
        lit_ext     = e;
        lit_kv      = kv;
        lit_ev      = ev;
        lit_ovf     = ovf;
        lit_ferr    = ferr;
        lit_code    = lc;
        lit_keys_en = keys_en;
        lit_keys    = kk;
        lit_seq++;
        repeat (2) @(negedge sys_clk);
    endtask

    // Single compare process: model-vs-DUT every cycle, reset checks, literal snapshots
    initial begin : compare
        int         last_post;
        int         last_lit;
        bit         pend;
        int         pend_cyc;
        logic [7:0] pend_byte;
        bit         pend_err;
        int         pend_win;
        int         ferr_in_win;
        int         ev_total;
        int         ovf_total;
        int         ferr_total;
        logic [8:0] last_code;
        bit         exp_ev;
        bit         exp_brk;
        bit         exp_ovf;
        logic [8:0] exp_code;
        last_post = 0; last_lit = 0; pend = 1'b0; pend_cyc = 0; pend_byte = 8'h00;
        pend_err = 1'b0; pend_win = 0; ferr_in_win = 0; ev_total = 0; ovf_total = 0;
        ferr_total = 0; last_code = 9'h000;
        forever begin
            @(negedge sys_clk or negedge async_rst_n);
            #1;
            if (!async_rst_n) begin
                held.delete();
                ext_f     = 1'b0;
                brk_f     = 1'b0;
                pend      = 1'b0;
                last_post = post_seq;
                checkOutput("rst_key", 64'(key), 64'(0));
                checkOutput("rst_key_ext", 64'(key_ext), 64'(0));
                checkOutput("rst_keys", 64'(keys), 64'(0));
                checkOutput("rst_key_valid", 64'(key_valid), 64'(0));
                checkOutput("rst_event_valid", 64'(event_valid), 64'(0));
                checkOutput("rst_event_code", 64'(event_code), 64'(0));
                checkOutput("rst_event_break", 64'(event_break), 64'(0));
                checkOutput("rst_frame_err", 64'(frame_err), 64'(0));
                checkOutput("rst_overflow", 64'(overflow), 64'(0));
            end else begin
                if (post_seq != last_post) begin
                    last_post   = post_seq;
                    pend        = 1'b1;
                    pend_cyc    = post_cyc;
                    pend_byte   = post_byte;
                    pend_err    = post_err;
                    pend_win    = post_win;
                    ferr_in_win = 0;
                end
                exp_ev   = 1'b0;
                exp_brk  = 1'b0;
                exp_ovf  = 1'b0;
                exp_code = 9'h000;
                if (pend && !pend_err && cyc == pend_cyc + LAT) begin
                    model_byte(pend_byte, exp_ev, exp_code, exp_brk, exp_ovf);
                    pend = 1'b0;
                end
                if (event_valid) begin
                    ev_total++;
                    last_code = event_code;
                end
                if (overflow) ovf_total++;
                if (frame_err) ferr_total++;
                if (pend && pend_err) begin
                    if (frame_err) ferr_in_win++;
                    if (cyc == pend_cyc + pend_win) begin
                        checkOutput("frame_err_count", 64'(ferr_in_win), 64'(1));
                        ext_f = 1'b0;
                        brk_f = 1'b0;
                        pend  = 1'b0;
                    end
                end else begin
                    checkOutput("spurious_frame_err", 64'(frame_err), 64'(0));
                end
                checkOutput("event_valid", 64'(event_valid), 64'(exp_ev));
                if (exp_ev) begin
                    checkOutput("event_code", 64'(event_code), 64'(exp_code));
                    checkOutput("event_break", 64'(event_break), 64'(exp_brk));
                end
                checkOutput("overflow", 64'(overflow), 64'(exp_ovf));
                checkOutput("key", 64'(key), 64'(model_slot0() & 9'h0FF));
                checkOutput("key_ext", 64'(key_ext), 64'(model_slot0() >> 8));
                checkOutput("keys", 64'(keys), 64'(model_keys()));
                checkOutput("key_valid", 64'(key_valid), 64'(model_kv()));
                if (lit_seq != last_lit) begin
                    last_lit = lit_seq;
                    checkOutput("lit_key", 64'(key), 64'(lit_key));
                    checkOutput("lit_key_ext", 64'(key_ext), 64'(lit_ext));
                    checkOutput("lit_key_valid", 64'(key_valid), 64'(lit_kv));
                    checkOutput("lit_model_kv", 64'(model_kv()), 64'(lit_kv));
                    checkOutput("lit_model_key", 64'(model_slot0()), 64'({lit_ext, lit_key}));
                    checkOutput("lit_events", 64'(ev_total), 64'(lit_ev));
                    checkOutput("lit_overflows", 64'(ovf_total), 64'(lit_ovf));
                    checkOutput("lit_frame_errs", 64'(ferr_total), 64'(lit_ferr));
                    checkOutput("lit_last_code", 64'(last_code), 64'(lit_code));
                    if (lit_keys_en) begin
                        checkOutput("lit_keys", 64'(keys), 64'(lit_keys));
                        checkOutput("lit_model_keys", 64'(model_keys()), 64'(lit_keys));
                    end
                end
            end
        end
    end

    // Directed scenarios
    initial begin : stimulus
        #1 async_rst_n = 1'b0;
        repeat (5) @(negedge sys_clk);
        async_rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        post_literal(8'h00, 0, 4'b0000, 0, 0, 0, 9'h000, 1, '0);

        $display("[TB] typematic repeat filtering");
        applyStimulus(8'h15, 0, 0, 11, 0);
        post_literal(8'h15, 0, 4'b0001, 1, 0, 0, 9'h015, 0, '0);
        repeat (4) applyStimulus(8'h15, 0, 0, 11, 0);
        post_literal(8'h15, 0, 4'b0001, 1, 0, 0, 9'h015, 0, '0);
        applyStimulus(8'hF0, 0, 0, 11, 0);
        applyStimulus(8'h15, 0, 0, 11, 0);
        post_literal(8'h00, 0, 4'b0000, 2, 0, 0, 9'h015, 0, '0);

        $display("[TB] oldest key stays in slot 0");
        applyStimulus(8'h1D, 0, 0, 11, 0);
        applyStimulus(8'h1D, 0, 0, 11, 0);
        applyStimulus(8'h15, 0, 0, 11, 0);
        applyStimulus(8'hF0, 0, 0, 11, 0);
        applyStimulus(8'h15, 0, 0, 11, 0);
        applyStimulus(8'h2D, 0, 0, 11, 0);
        applyStimulus(8'hF0, 0, 0, 11, 0);
        applyStimulus(8'h2D, 0, 0, 11, 0);
        post_literal(8'h1D, 0, 4'b0001, 7, 0, 0, 9'h02D, 0, '0);
        applyStimulus(8'hF0, 0, 0, 11, 0);
        applyStimulus(8'h1D, 0, 0, 11, 0);
        post_literal(8'h00, 0, 4'b0000, 8, 0, 0, 9'h01D, 0, '0);

        $display("[TB] full table, overflow and middle removal");
        applyStimulus(8'h1C, 0, 0, 11, 0);
        applyStimulus(8'h1B, 0, 0, 11, 0);
        applyStimulus(8'h23, 0, 0, 11, 0);
        applyStimulus(8'h2B, 0, 0, 11, 0);
        post_literal(8'h1C, 0, 4'b1111, 12, 0, 0, 9'h02B, 1,
                     {9'h02B, 9'h023, 9'h01B, 9'h01C});
        applyStimulus(8'h34, 0, 0, 11, 0);
        post_literal(8'h1C, 0, 4'b1111, 12, 1, 0, 9'h02B, 0, '0);
        applyStimulus(8'hF0, 0, 0, 11, 0);
        applyStimulus(8'h1B, 0, 0, 11, 0);
        post_literal(8'h1C, 0, 4'b0111, 13, 1, 0, 9'h01B, 1,
                     {9'h000, 9'h02B, 9'h023, 9'h01C});
        applyStimulus(8'hF0, 0, 0, 11, 0);
        applyStimulus(8'h1C, 0, 0, 11, 0);
        applyStimulus(8'hF0, 0, 0, 11, 0);
        applyStimulus(8'h23, 0, 0, 11, 0);
        applyStimulus(8'hF0, 0, 0, 11, 0);
        applyStimulus(8'h2B, 0, 0, 11, 0);
        post_literal(8'h00, 0, 4'b0000, 16, 1, 0, 9'h02B, 1, '0);

        $display("[TB] extended codes");
        applyStimulus(8'hE0, 0, 0, 11, 0);
        applyStimulus(8'h75, 0, 0, 11, 0);
        post_literal(8'h75, 1, 4'b0001, 17, 1, 0, 9'h175, 0, '0);
        applyStimulus(8'hF0, 0, 0, 11, 0);
        applyStimulus(8'h75, 0, 0, 11, 0);
        post_literal(8'h75, 1, 4'b0001, 17, 1, 0, 9'h175, 0, '0);
        applyStimulus(8'hE0, 0, 0, 11, 0);
        applyStimulus(8'hF0, 0, 0, 11, 0);
        applyStimulus(8'h75, 0, 0, 11, 0);
        post_literal(8'h00, 0, 4'b0000, 18, 1, 0, 9'h175, 0, '0);

        $display("[TB] parity and stop errors");
        applyStimulus(8'h15, 1, 0, 11, 0);
        post_literal(8'h00, 0, 4'b0000, 18, 1, 1, 9'h175, 0, '0);
        applyStimulus(8'h15, 0, 1, 11, 0);
        post_literal(8'h00, 0, 4'b0000, 18, 1, 2, 9'h175, 0, '0);

        $display("[TB] timeout, recovery and asynchronous reset");
        applyStimulus(8'h15, 0, 0, 5, 1);
        repeat (TO + 60) @(negedge sys_clk);
        post_literal(8'h00, 0, 4'b0000, 18, 1, 3, 9'h175, 0, '0);
        applyStimulus(8'h15, 0, 0, 11, 0);
        post_literal(8'h15, 0, 4'b0001, 19, 1, 3, 9'h015, 0, '0);
        applyStimulus(8'h1C, 0, 0, 4, 0);
        @(posedge sys_clk);
        #2 async_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        async_rst_n = 1'b1;
        repeat (10) @(negedge sys_clk);
        applyStimulus(8'h15, 0, 0, 11, 0);
        post_literal(8'h15, 0, 4'b0001, 20, 1, 3, 9'h015, 0, '0);

        repeat (20) @(negedge sys_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
